alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Parametrised, registered ALU control unit for the next-generation datapath. It decodes {ALUop, funct} into the ALU operation code, extending the existing code set with slt/xor/nor/sra and iterative mult/div. A valid/ready handshake sits on each side of the block. For the iterative ops, an internal counter holds the op, asserts busy, and drives a per-iteration step strobe to the datapath. The block sits between the main control unit and the ALU/multiplier-divider.

Parameters:
OPW, 4, ALU op code width; must be >= 4; codes are zero-extended into OPW bits.
FUNCTW, 6, funct field width; only bits [5:0] are decoded, upper bits must be 0 or the instruction is illegal.
MULT_CYCLES, 4, iterations for mult/multu; legal range 2..255.
DIV_CYCLES, 8, iterations for div/divu; legal range 2..255.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; drops the held result and any in-flight iteration
in_valid  in  1  decode request valid
in_ready  out  1  block can accept a request this cycle
alu_src_op  in  2  00 R-type decode, 01 pass B (li), 10 add (lw/sw/addi), 11 sub (beq)
funct  in  FUNCTW  instruction funct field
out_valid  out  1  alu_op/illegal valid
out_ready  in  1  consumer accepts result
alu_op  out  OPW  decoded ALU op code
illegal  out  1  qualifies out_valid; the R-type funct was not recognised
busy  out  1  iterative op in progress
alu_step  out  1  one-cycle strobe per mult/div iteration

Behaviour:
- Op codes: AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, SLT 0110, PASSB 0111, XOR 1000, NOR 1001, SRA 1010, MULT 1011, DIV 1100, NOP 1111.
- Decode for alu_src_op = 00 (funct):
  - 100000/100001 -> ADD; 100010/100011 -> SUB.
  - 100100 -> AND; 100101 -> OR; 100110 -> XOR; 100111 -> NOR.
  - 101010 -> SLT.
  - 000000 -> SLL; 000010 -> SRL; 000011 -> SRA.
  - 011000/011001 -> MULT; 011010/011011 -> DIV.
  - Anything else -> NOP with illegal = 1.
- Decode for other alu_src_op values: 01 -> PASSB, 10 -> ADD, 11 -> SUB. funct is ignored and illegal is never set.
- States: IDLE (output register empty), HOLD (result valid, waiting for out_ready), ITER (mult/div counting).
- in_ready = (state == IDLE) or (state == HOLD and out_ready). in_ready is always 0 in ITER and while flush is asserted.
- Accept occurs when in_valid & in_ready.
  - Non-iterative op: alu_op/illegal are registered and out_valid = 1 on the next cycle (latency 1), state HOLD.
  - Back-to-back accepts in HOLD give a throughput of 1 per cycle.
- Accept of MULT/DIV:
  - alu_op is registered, busy = 1, counter loads N-1 (N = MULT_CYCLES or DIV_CYCLES), state ITER.
  - alu_step = 1 every ITER cycle. The counter decrements each cycle.
  - The cycle after the counter reaches 0: busy = 0, alu_step = 0, out_valid = 1, state HOLD.
  - Result: first out_valid is N+1 cycles after the accept edge, with exactly N alu_step pulses.
- HOLD: alu_op and illegal stay stable while out_valid = 1 and out_ready = 0.
  - If out_ready = 1 and there is no new accept, the next state is IDLE with out_valid = 0.
- flush (priority over everything except reset):
  - Next cycle: state IDLE, out_valid = 0, busy = 0, alu_step = 0, counter = 0.
  - A request presented in the same cycle is not accepted.
- Reset (any time, including mid-ITER): immediately alu_op = 0, out_valid = 0, illegal = 0, busy = 0, alu_step = 0, counter = 0, state IDLE. in_ready = 1 after reset deasserts.
- Outputs are registered except in_ready, which is combinational from state and out_ready.
- Counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)+1). No wrap: the counter never decrements below 0.
- illegal = 1 only together with out_valid = 1 and alu_op = NOP. An illegal request never enters ITER.

Test Plan:
- Reset, then alu_src_op=00, funct=100010, one in_valid pulse, out_ready=1 -> next cycle out_valid=1, alu_op=0011, illegal=0; the cycle after, out_valid=0.
- Stream 100000, 100100, 000011, alu_src_op=01 on consecutive cycles with out_ready=1 -> in_ready stays 1; outputs 0010, 0000, 1010, 0111 on consecutive cycles.
- funct=011000 with MULT_CYCLES=4 -> busy=1 and alu_step=1 for 4 cycles, in_ready=0 throughout; out_valid=1 with alu_op=1011 on the 5th cycle after accept.
- funct=011010 (DIV_CYCLES=8), flush on the 3rd ITER cycle -> next cycle busy=0, out_valid=0, in_ready=1, no result ever produced; then rst_n pulled low mid-ITER -> all outputs 0 asynchronously.
- funct=111111, alu_src_op=00 -> out_valid=1, alu_op=1111, illegal=1; same funct with alu_src_op=10 -> alu_op=0010, illegal=0.
- out_ready=0 for 5 cycles after a SUB result -> out_valid, alu_op=0011 held stable, in_ready=0; out_ready=1 with a new in_valid (funct=100101) in the same cycle -> next cycle alu_op=0001, out_valid=1.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control unit with valid/ready handshakes.
//
// Decodes {alu_src_op, funct} into an ALU op code. Multiply and divide are
// iterative: the block stays busy for MULT_CYCLES / DIV_CYCLES cycles and
// pulses alu_step once per iteration before it presents the result.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   flush                 synchronous abort of any held or in-flight operation
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   alu_src_op, funct     decode inputs
//   out_valid / out_ready result handshake
//   alu_op, illegal       decoded op code; illegal marks an unknown R-type funct
//   busy, alu_step        iterative op in progress / per-iteration strobe
module alu_ctrl_seq #(
    parameter int OPW         = 4,
    parameter int FUNCTW      = 6,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_src_op,
    input  logic [FUNCTW-1:0] funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPW-1:0]    alu_op,
    output logic              illegal,
    output logic              busy,
    output logic              alu_step
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_ITER = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [3:0] dec_op;
    logic       dec_ill;
    logic       dec_mult;
    logic       dec_div;
    logic       funct_hi_zero;
    logic       accept;

    // Any funct bit above [5:0] being set makes an R-type request illegal.
    assign funct_hi_zero = ((funct >> 6) == '0);

    always_comb begin
        dec_op  = OP_NOP;
        dec_ill = 1'b0;
        unique case (alu_src_op)
            2'b01: dec_op = OP_PASSB;
            2'b10: dec_op = OP_ADD;
            2'b11: dec_op = OP_SUB;
            default: begin
                case (funct[5:0])
                    6'b100000, 6'b100001: dec_op = OP_ADD;
                    6'b100010, 6'b100011: dec_op = OP_SUB;
                    6'b100100:            dec_op = OP_AND;
                    6'b100101:            dec_op = OP_OR;
                    6'b100110:            dec_op = OP_XOR;
                    6'b100111:            dec_op = OP_NOR;
                    6'b101010:            dec_op = OP_SLT;
                    6'b000000:            dec_op = OP_SLL;
                    6'b000010:            dec_op = OP_SRL;
                    6'b000011:            dec_op = OP_SRA;
                    6'b011000, 6'b011001: dec_op = OP_MULT;
                    6'b011010, 6'b011011: dec_op = OP_DIV;
                    default:              dec_ill = 1'b1;
                endcase
                if (!funct_hi_zero) begin
                    dec_ill = 1'b1;
                end
                if (dec_ill) begin
                    dec_op = OP_NOP;
                end
            end
        endcase
    end

    assign dec_mult = (dec_op == OP_MULT);
    assign dec_div  = (dec_op == OP_DIV);

    assign in_ready = !flush && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            alu_op    <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            alu_step  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            alu_step  <= 1'b0;
        end else if (accept) begin
            alu_op <= OPW'(dec_op);
            if (dec_mult || dec_div) begin
                // Counter holds iterations remaining after the current one.
                state     <= S_ITER;
                cnt       <= dec_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                illegal   <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b1;
                alu_step  <= 1'b1;
            end else begin
                state     <= S_HOLD;
                illegal   <= dec_ill;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                S_ITER: begin
                    if (cnt == '0) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        alu_step  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_alu_ctrl_seq;

    localparam int MC = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] alu_src_op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_op;
    logic       illegal;
    logic       busy;
    logic       alu_step;

    int nChecks = 0;
    int nPass = 0;

    alu_ctrl_seq #(.OPW(4), .FUNCTW(6), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_src_op(alu_src_op), .funct(funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .illegal(illegal),
        .busy(busy), .alu_step(alu_step)
    );

    always #5 clk = ~clk;

    // Behavioural model: a held result slot plus a count of busy cycles left.
    logic       mHold;
    logic [3:0] mOp;
    logic       mIll;
    int         mIterLeft;

    typedef struct {
        logic [3:0] op;
        logic       ill;
        int         iters;
    } dec_t;

    function automatic dec_t refDecode(input logic [1:0] src, input logic [5:0] fn);
        dec_t d;
        d.op = 4'hF; d.ill = 1'b0; d.iters = 0;
        if (src == 2'b01) d.op = 4'h7;
        else if (src == 2'b10) d.op = 4'h2;
        else if (src == 2'b11) d.op = 4'h3;
        else begin
            case (fn)
                6'd32, 6'd33: d.op = 4'h2;
                6'd34, 6'd35: d.op = 4'h3;
                6'd36: d.op = 4'h0;
                6'd37: d.op = 4'h1;
                6'd38: d.op = 4'h8;
                6'd39: d.op = 4'h9;
                6'd42: d.op = 4'h6;
                6'd0:  d.op = 4'h4;
                6'd2:  d.op = 4'h5;
                6'd3:  d.op = 4'hA;
                6'd24, 6'd25: begin d.op = 4'hB; d.iters = MC; end
                6'd26, 6'd27: begin d.op = 4'hC; d.iters = DC; end
                default: d.ill = 1'b1;
            endcase
        end
        return d;
    endfunction

    function automatic logic modelReady(input logic ordy, input logic fl);
        return !fl && (mIterLeft == 0) && (!mHold || ordy);
    endfunction

    task automatic modelReset();
        mHold = 1'b0; mOp = 4'h0; mIll = 1'b0; mIterLeft = 0;
    endtask

    task automatic modelEdge(input logic iv, input logic [1:0] src, input logic [5:0] fn,
                             input logic ordy, input logic fl);
        dec_t d;
        logic rdy;
        rdy = modelReady(ordy, fl);
        d = refDecode(src, fn);
        if (fl) begin
            mHold = 1'b0; mIll = 1'b0; mIterLeft = 0;
        end else if (iv && rdy) begin
            mOp = d.op;
            if (d.iters > 0) begin
                mIterLeft = d.iters; mHold = 1'b0; mIll = 1'b0;
            end else begin
                mHold = 1'b1; mIll = d.ill;
            end
        end else if (mIterLeft > 0) begin
            mIterLeft--;
            if (mIterLeft == 0) mHold = 1'b1;
        end else if (mHold && ordy) begin
            mHold = 1'b0; mIll = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".out_valid"}, int'(out_valid), int'(mHold));
        checkOutput({tag, ".illegal"}, int'(illegal), int'(mHold ? mIll : 1'b0));
        checkOutput({tag, ".busy"}, int'(busy), int'(mIterLeft > 0));
        checkOutput({tag, ".alu_step"}, int'(alu_step), int'(mIterLeft > 0));
        if (mHold || mIterLeft > 0) checkOutput({tag, ".alu_op"}, int'(alu_op), int'(mOp));
    endtask

    // One clock cycle: drive at negedge, check in_ready, then check registered outputs.
    task automatic applyStimulus(input string tag, input logic iv, input logic [1:0] src,
                                 input logic [5:0] fn, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = iv; alu_src_op = src; funct = fn; out_ready = ordy; flush = fl;
        #1;
        checkOutput({tag, ".in_ready"}, int'(in_ready), int'(modelReady(ordy, fl)));
        @(posedge clk);
        modelEdge(iv, src, fn, ordy, fl);
        #1;
        checkModel(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        modelReset();
        checkOutput("reset.out_valid", int'(out_valid), 0);
        checkOutput("reset.alu_op", int'(alu_op), 0);
        checkOutput("reset.illegal", int'(illegal), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.alu_step", int'(alu_step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset.in_ready", int'(in_ready), 1);
    endtask

    typedef struct {
        logic       iv;
        logic [1:0] src;
        logic [5:0] fn;
        logic       ordy;
        logic       erdy;
        logic       ev;
        logic [3:0] eop;
        logic       eill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int stepsSeen;
        int firstValid;
        int pool[14];
        modelReset();
        pool = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 0, 2, 3, 24, 26};

        // {iv, src, funct, out_ready, exp in_ready, exp out_valid, exp op, exp illegal}
        vecs.push_back('{1, 2'b00, 6'b100010, 1, 1, 1, 4'h3, 0});
        vecs.push_back('{0, 2'b00, 6'b000000, 1, 1, 0, 4'h0, 0});
        vecs.push_back('{1, 2'b00, 6'b100000, 1, 1, 1, 4'h2, 0});
        vecs.push_back('{1, 2'b00, 6'b100100, 1, 1, 1, 4'h0, 0});
        vecs.push_back('{1, 2'b00, 6'b000011, 1, 1, 1, 4'hA, 0});
        vecs.push_back('{1, 2'b01, 6'b010101, 1, 1, 1, 4'h7, 0});
        vecs.push_back('{0, 2'b00, 6'b000000, 1, 1, 0, 4'h0, 0});
        vecs.push_back('{1, 2'b00, 6'b111111, 1, 1, 1, 4'hF, 1});
        vecs.push_back('{1, 2'b10, 6'b111111, 1, 1, 1, 4'h2, 0});
        vecs.push_back('{1, 2'b00, 6'b100111, 1, 1, 1, 4'h9, 0});
        vecs.push_back('{1, 2'b00, 6'b101010, 1, 1, 1, 4'h6, 0});
        vecs.push_back('{0, 2'b00, 6'b000000, 1, 1, 0, 4'h0, 0});
        vecs.push_back('{1, 2'b00, 6'b100011, 0, 1, 1, 4'h3, 0});
        for (int i = 0; i < 5; i++) vecs.push_back('{0, 2'b00, 6'b000000, 0, 0, 1, 4'h3, 0});
        vecs.push_back('{1, 2'b00, 6'b100101, 1, 1, 1, 4'h1, 0});
        vecs.push_back('{0, 2'b00, 6'b000000, 1, 1, 0, 4'h0, 0});

        doReset();

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].iv; alu_src_op = vecs[i].src; funct = vecs[i].fn;
            out_ready = vecs[i].ordy; flush = 1'b0;
            #1;
            checkOutput($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].erdy));
            @(posedge clk);
            modelEdge(vecs[i].iv, vecs[i].src, vecs[i].fn, vecs[i].ordy, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].ev));
            checkOutput($sformatf("vec%0d.illegal", i), int'(illegal), int'(vecs[i].eill));
            if (vecs[i].ev) checkOutput($sformatf("vec%0d.alu_op", i), int'(alu_op), int'(vecs[i].eop));
        end

        // MULT: exactly MC step pulses, result on cycle MC+1 after the accept edge.
        applyStimulus("mult.acc", 1, 2'b00, 6'b011000, 1, 0);
        stepsSeen = 0;
        firstValid = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (alu_step) stepsSeen++;
            if (out_valid && firstValid == 0) begin
                firstValid = cyc;
                checkOutput("mult.alu_op", int'(alu_op), 11);
            end
            if (cyc < 8) applyStimulus("mult.run", 0, 2'b00, 6'd0, 1, 0);
        end
        checkOutput("mult.steps", stepsSeen, MC);
        checkOutput("mult.latency", firstValid, MC + 1);

        // DIV aborted by flush on the third iteration; a request in that cycle is dropped.
        applyStimulus("div.acc", 1, 2'b00, 6'b011010, 1, 0);
        applyStimulus("div.it1", 0, 2'b00, 6'd0, 1, 0);
        applyStimulus("div.it2", 0, 2'b00, 6'd0, 1, 0);
        applyStimulus("div.flush", 1, 2'b00, 6'b100000, 1, 1);
        checkOutput("div.flush.busy", int'(busy), 0);
        checkOutput("div.flush.out_valid", int'(out_valid), 0);
        for (int i = 0; i < DC + 2; i++) applyStimulus("div.after", 0, 2'b00, 6'd0, 1, 0);

        // Reset asserted mid-iteration clears outputs without waiting for a clock.
        applyStimulus("rst.acc", 1, 2'b00, 6'b011011, 1, 0);
        applyStimulus("rst.it1", 0, 2'b00, 6'd0, 1, 0);
        applyStimulus("rst.it2", 0, 2'b00, 6'd0, 1, 0);
        checkOutput("rst.pre.busy", int'(busy), 1);
        doReset();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic       iv;
            logic [1:0] src;
            logic [5:0] fn;
            logic       ordy;
            logic       fl;
            iv   = ($urandom_range(0, 9) < 6);
            src  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fn   = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'(pool[$urandom_range(0, 13)]);
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 29) == 0);
            applyStimulus("rand", iv, src, fn, ordy, fl);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
